// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive GCD engine: controller state encoding
// and the default operand width.
package gcd_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StCalc = 1'b1
  } state_e;

endpackage

// File: rtl/gcd_if.sv
// Request/result bundle of the GCD engine. The requester drives go_i/x_i/y_i;
// the engine returns d_o/done_o/busy_o.
interface gcd_if #(
  parameter int unsigned W = gcd_pkg::DefaultWidth
) ();

  logic         go_i;
  logic [W-1:0] x_i;
  logic [W-1:0] y_i;
  logic [W-1:0] d_o;
  logic         done_o;
  logic         busy_o;

  modport master (
    output go_i,
    output x_i,
    output y_i,
    input  d_o,
    input  done_o,
    input  busy_o
  );

  modport slave (
    input  go_i,
    input  x_i,
    input  y_i,
    output d_o,
    output done_o,
    output busy_o
  );

endinterface

// File: rtl/gcd_datapath.sv
// Operand registers xr/yr with comparator and the two subtractors. The
// controller only ever asserts the subtract whose minuend is the larger value.
module gcd_datapath #(
  parameter int unsigned W = gcd_pkg::DefaultWidth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         sub_x_i,
  input  logic         sub_y_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] xr_o,
  output logic         gt_o,
  output logic         eq_o
);

  logic [W-1:0] xr_q, xr_d;
  logic [W-1:0] yr_q, yr_d;

  always_comb begin
    xr_d = xr_q;
    yr_d = yr_q;
    if (load_i) begin
      xr_d = x_i;
      yr_d = y_i;
    end else if (sub_x_i) begin
      xr_d = xr_q - yr_q;
    end else if (sub_y_i) begin
      yr_d = yr_q - xr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xr_q <= '0;
      yr_q <= '0;
    end else begin
      xr_q <= xr_d;
      yr_q <= yr_d;
    end
  end

  assign xr_o = xr_q;
  assign gt_o = (xr_q > yr_q);
  assign eq_o = (xr_q == yr_q);

endmodule

// File: rtl/gcd_engine.sv
// Subtractive GCD engine: IDLE/CALC controller, result register and done
// pulse, driving the gcd_datapath operand registers.
module gcd_engine import gcd_pkg::*; #(
  parameter int unsigned W = DefaultWidth
) (
  input logic  clk,
  input logic  rst,
  gcd_if.slave bus
);

  state_e       state_q, state_d;
  logic [W-1:0] d_q, d_d;
  logic         done_q, done_d;

  logic         load, sub_x, sub_y;
  logic         gt, eq;
  logic [W-1:0] xr;

  gcd_datapath #(
    .W (W)
  ) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .sub_x_i (sub_x),
    .sub_y_i (sub_y),
    .x_i     (bus.x_i),
    .y_i     (bus.y_i),
    .xr_o    (xr),
    .gt_o    (gt),
    .eq_o    (eq)
  );

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    done_d  = 1'b0;
    load    = 1'b0;
    sub_x   = 1'b0;
    sub_y   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.go_i) begin
          if ((bus.x_i != '0) && (bus.y_i != '0)) begin
            load    = 1'b1;
            state_d = StCalc;
          end else begin
            // gcd(a,0) = a and gcd(0,0) = 0, so no iteration is needed.
            d_d    = bus.x_i | bus.y_i;
            done_d = 1'b1;
          end
        end
      end
      StCalc: begin
        if (eq) begin
          d_d     = xr;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (gt) begin
          sub_x = 1'b1;
        end else begin
          sub_y = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

  assign bus.d_o    = d_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = (state_q == StCalc);

endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 Parameter: W, default 4, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 go_i  input  1  start request, level-sampled while idle.
REQ-005 x_i  input  W  first operand, sampled on the edge that accepts go_i.
REQ-006 y_i  input  W  second operand, sampled on the edge that accepts go_i.
REQ-007 d_o  output  W  last computed GCD, registered, held until the next result or reset.
REQ-008 done_o  output  1  one-cycle pulse, high in the cycle d_o first shows a new result.
REQ-009 busy_o  output  1  high while a computation is in progress (state CALC).

Function
REQ-010 FSM states SHALL be IDLE and CALC only.
REQ-011 IDLE, go_i=1, x_i!=0, y_i!=0: load x_i and y_i into internal registers xr and yr; next state CALC.
REQ-012 IDLE, go_i=1, x_i or y_i zero: d_o <= x_i | y_i, done_o <= 1; remain IDLE; gcd(0,0)=0.
REQ-013 IDLE, go_i=0: hold xr, yr and d_o; done_o <= 0.
REQ-014 CALC, xr>yr: xr <= xr-yr; CALC, yr>xr: yr <= yr-xr; one subtraction per cycle.
REQ-015 CALC, xr==yr: d_o <= xr, done_o <= 1; next state IDLE.
REQ-016 Subtraction always takes the larger operand minus the smaller, so there is no underflow; all arithmetic is unsigned W-bit.
REQ-017 go_i is ignored in CALC; operands change only on acceptance in IDLE.
REQ-018 Latency: if go_i is accepted at edge 0 with n subtractions required, d_o is valid and done_o is high after edge n+1.
REQ-019 Worst case for W=4 is (15,1) or (1,15): 14 subtractions, result after 15 edges, so it completes within 30 cycles.
REQ-020 If go_i is held high through a completion, a new computation is accepted on the first IDLE edge; this is legal.
REQ-021 done_o SHALL never be high for two consecutive cycles from a single computation.
REQ-022 busy_o SHALL be combinational from the state register: 1 if and only if state==CALC.

Reset
REQ-023 With rst=1 at a rising edge: state=IDLE, xr=0, yr=0, d_o=0, done_o=0.
REQ-024 rst overrides go_i and any in-flight CALC; no partial result reaches d_o.
REQ-025 Operation resumes on the first edge with rst=0; go_i is sampled on that edge.

Structure
REQ-026 A shared package gcd_pkg SHALL hold the state encoding (IDLE=0, CALC=1) and the default width constant (4).
REQ-027 The single sub-module gcd_datapath SHALL contain xr, yr, the comparator (gt, eq) and the two subtractors.
REQ-028 The top-level gcd_engine SHALL contain the FSM, the d_o register, done_o and the datapath control (load, sub_x, sub_y).

Verification
REQ-029 rst for 2 cycles, then go with (12,8) -> d_o=4 and done_o pulse after edge 3; busy_o high for 3 cycles.
REQ-030 Sequence (14,7)->7, (15,13)->1, (5,15)->5, (8,7)->1, (15,2)->1; each result must be correct within 30 cycles of go.
REQ-031 (6,6) -> d_o=6 after edge 1; (15,1) -> d_o=1 after edge 15.
REQ-032 (0,9) -> d_o=9, done_o high after edge 0, busy_o never high; (0,0) -> d_o=0.
REQ-033 Start (15,1), pulse go with (12,8) at cycle 3 -> pulse ignored, result 1; rst at cycle 5 -> d_o=0, no done_o.
REQ-034 Hold go_i high with (12,8) -> repeated results of 4, done_o pulses every 4 cycles, never two consecutive.
